// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the instruction Ram combinationally,
// and registers the fetched word into the IF/ID register. It honours stall, flush and
// redirect requests, and redirects locally on predecoded J-type jumps.
module instr_fetch_unit #(
   parameter int ADDR_WIDTH     = 7,
   parameter int DATA_WIDTH     = 32,
   parameter int RESET_PC       = 0,
   parameter int BOOT_CYCLES    = 2,
   parameter int JUMP_PREDECODE = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_target,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic                  imem_wre,
   output logic                  imem_flag,
   input  logic [DATA_WIDTH-1:0] imem_data,
   output logic [DATA_WIDTH-1:0] if_instr,
   output logic [ADDR_WIDTH-1:0] if_pc,
   output logic [ADDR_WIDTH-1:0] if_pc_plus1,
   output logic                  if_valid,
   output logic [15:0]           fetch_count
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } stateType;

   stateType              state;
   stateType              stateNext;
   logic [3:0]            bootCount;
   logic [3:0]            bootNext;
   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] pcNext;
   logic [ADDR_WIDTH-1:0] pcPlus1;
   logic                  loadIfid;
   logic                  validNext;
   logic                  countInc;
   logic                  isJump;

   assign imem_addr = pc;
   assign imem_wre  = 1'b1;
   assign imem_flag = 1'b1;
   assign pcPlus1   = pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   assign isJump    = (JUMP_PREDECODE != 0) && (imem_data[DATA_WIDTH-1 -: 6] == 6'b000010);

   // Next-state and next-PC decision; redirect beats flush, flush beats stall, stall beats a normal fetch
   always_comb begin
      stateNext = state;
      bootNext  = bootCount;
      pcNext    = pc;
      loadIfid  = 1'b0;
      validNext = if_valid;
      countInc  = 1'b0;
      case (state)
         BOOT: begin
            validNext = 1'b0;
            if (bootCount == 4'(BOOT_CYCLES - 1)) begin
               stateNext = RUN;
            end else begin
               bootNext = bootCount + 4'd1;
            end
         end
         RUN, HOLD: begin
            if (redirect_valid) begin
               pcNext    = redirect_target;
               validNext = 1'b0;
               stateNext = RUN;
            end else if (flush) begin
               validNext = 1'b0;
               if (!stall) begin
                  pcNext = pcPlus1;
               end
               stateNext = stall ? HOLD : RUN;
            end else if (stall) begin
               stateNext = HOLD;
            end else begin
               loadIfid  = 1'b1;
               validNext = 1'b1;
               countInc  = 1'b1;
               pcNext    = isJump ? imem_data[ADDR_WIDTH-1:0] : pcPlus1;
               stateNext = RUN;
            end
         end
         default: begin
            stateNext = BOOT;
         end
      endcase
   end

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= BOOT;
      end else begin
         state <= stateNext;
      end
   end

   // PC and boot-delay counter
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc        <= ADDR_WIDTH'(RESET_PC);
         bootCount <= 4'd0;
      end else begin
         pc        <= pcNext;
         bootCount <= bootNext;
      end
   end

   // IF/ID register: the word at pc is captured on the same edge that advances pc
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         if_instr    <= '0;
         if_pc       <= '0;
         if_pc_plus1 <= '0;
         if_valid    <= 1'b0;
      end else begin
         if_valid <= validNext;
         if (loadIfid) begin
            if_instr    <= imem_data;
            if_pc       <= pc;
            if_pc_plus1 <= pcPlus1;
         end
      end
   end

   // Saturating count of words accepted into IF/ID
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_count <= 16'd0;
      end else if (countInc && (fetch_count != 16'hFFFF)) begin
         fetch_count <= fetch_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with a combinational Ram model.
module tb_instr_fetch_unit;

   logic        clock;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        redirect_valid;
   logic [6:0]  redirect_target;
   logic [6:0]  imem_addr;
   logic        imem_wre;
   logic        imem_flag;
   logic [31:0] imem_data;
   logic [31:0] if_instr;
   logic [6:0]  if_pc;
   logic [6:0]  if_pc_plus1;
   logic        if_valid;
   logic [15:0] fetch_count;

   logic [31:0] mem [0:127];
   int          compareCount;
   int          mismatchCount;

   instr_fetch_unit dut (
      .clock           (clock),
      .reset           (reset),
      .stall           (stall),
      .flush           (flush),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .imem_addr       (imem_addr),
      .imem_wre        (imem_wre),
      .imem_flag       (imem_flag),
      .imem_data       (imem_data),
      .if_instr        (if_instr),
      .if_pc           (if_pc),
      .if_pc_plus1     (if_pc_plus1),
      .if_valid        (if_valid),
      .fetch_count     (fetch_count)
   );

   assign imem_data = mem[imem_addr];

   // Free-running clock, period 10
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Expected Ram contents: non-jump words tagged with their address, a jump to 15 at 3
   function automatic logic [31:0] memWord(input int addr);
      if (addr == 3) return 32'h0800000F;
      return 32'h20000000 | 32'(addr);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic f, input logic rv, input logic [6:0] rt);
      stall           = s;
      flush           = f;
      redirect_valid  = rv;
      redirect_target = rt;
   endtask

   // Advance one clock edge and sample shortly after it
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Check that IF/ID holds a valid fetch from address a with the given count
   task automatic checkFetch(input string tag, input int a, input int cnt);
      checkOutput({tag, ".valid"}, 32'(if_valid), 32'd1);
      checkOutput({tag, ".pc"}, 32'(if_pc), 32'(a));
      checkOutput({tag, ".pc1"}, 32'(if_pc_plus1), 32'((a + 1) % 128));
      checkOutput({tag, ".instr"}, if_instr, memWord(a));
      checkOutput({tag, ".count"}, 32'(fetch_count), 32'(cnt));
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".valid"}, 32'(if_valid), 32'd0);
      checkOutput({tag, ".pc"}, 32'(if_pc), 32'd0);
      checkOutput({tag, ".pc1"}, 32'(if_pc_plus1), 32'd0);
      checkOutput({tag, ".instr"}, if_instr, 32'd0);
      checkOutput({tag, ".count"}, 32'(fetch_count), 32'd0);
      checkOutput({tag, ".addr"}, 32'(imem_addr), 32'd0);
   endtask

   initial begin
      compareCount  = 0;
      mismatchCount = 0;
      for (int i = 0; i < 128; i++) mem[i] = memWord(i);
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 7'd0);

      // Reset held for three cycles
      repeat (3) step();
      checkAllZero("reset");
      checkOutput("wre", 32'(imem_wre), 32'd1);
      checkOutput("flag", 32'(imem_flag), 32'd1);

      // Release between edges, then two boot edges with no valid output
      #4 reset = 1'b1;
      step();
      checkOutput("boot1.valid", 32'(if_valid), 32'd0);
      checkOutput("boot1.addr", 32'(imem_addr), 32'd0);
      step();
      checkOutput("boot2.valid", 32'(if_valid), 32'd0);
      checkOutput("boot2.count", 32'(fetch_count), 32'd0);
      step(); checkFetch("f0", 0, 1);
      step(); checkFetch("f1", 1, 2);
      step(); checkFetch("f2", 2, 3);

      // Predecoded jump at address 3 goes straight to 15
      step(); checkFetch("jmp", 3, 4);
      checkOutput("jmp.addr", 32'(imem_addr), 32'd15);
      step(); checkFetch("jmp15", 15, 5);

      // Redirect to 4, fetch 4, then stall with pc=5
      applyStimulus(1'b0, 1'b0, 1'b1, 7'd4);
      step();
      checkOutput("redir4.valid", 32'(if_valid), 32'd0);
      checkOutput("redir4.addr", 32'(imem_addr), 32'd4);
      applyStimulus(1'b0, 1'b0, 1'b0, 7'd0);
      step(); checkFetch("f4", 4, 6);
      applyStimulus(1'b1, 1'b0, 1'b0, 7'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         checkFetch($sformatf("stall%0d", k), 4, 6);
         checkOutput($sformatf("stall%0d.addr", k), 32'(imem_addr), 32'd5);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 7'd0);
      step(); checkFetch("unstall", 5, 7);

      // Redirect beats stall and flush in the same cycle
      applyStimulus(1'b1, 1'b1, 1'b1, 7'd3);
      step();
      checkOutput("combo.valid", 32'(if_valid), 32'd0);
      checkOutput("combo.addr", 32'(imem_addr), 32'd3);
      checkOutput("combo.count", 32'(fetch_count), 32'd7);
      applyStimulus(1'b0, 1'b0, 1'b0, 7'd0);
      step(); checkFetch("combo3", 3, 8);

      // Flush alone advances pc without a valid word; flush with stall holds pc
      applyStimulus(1'b0, 1'b1, 1'b0, 7'd0);
      step();
      checkOutput("flush.valid", 32'(if_valid), 32'd0);
      checkOutput("flush.addr", 32'(imem_addr), 32'd16);
      checkOutput("flush.count", 32'(fetch_count), 32'd8);
      applyStimulus(1'b0, 1'b0, 1'b0, 7'd0);
      step(); checkFetch("f16", 16, 9);
      applyStimulus(1'b1, 1'b1, 1'b0, 7'd0);
      step();
      checkOutput("flushstall.valid", 32'(if_valid), 32'd0);
      checkOutput("flushstall.addr", 32'(imem_addr), 32'd17);
      applyStimulus(1'b0, 1'b0, 1'b0, 7'd0);
      step(); checkFetch("f17", 17, 10);

      // PC wraps from 127 to 0
      applyStimulus(1'b0, 1'b0, 1'b1, 7'd126);
      step();
      applyStimulus(1'b0, 1'b0, 1'b0, 7'd0);
      step(); checkFetch("w126", 126, 11);
      step(); checkFetch("w127", 127, 12);
      step(); checkFetch("w0", 0, 13);
      step(); checkFetch("w1", 1, 14);

      // Asynchronous reset mid-run at pc=20
      applyStimulus(1'b0, 1'b0, 1'b1, 7'd20);
      step();
      applyStimulus(1'b0, 1'b0, 1'b0, 7'd0);
      checkOutput("pre.addr", 32'(imem_addr), 32'd20);
      #2 reset = 1'b0;
      #1;
      checkAllZero("async");
      step();
      #4 reset = 1'b1;
      step();
      checkOutput("reboot1.valid", 32'(if_valid), 32'd0);
      step();
      checkOutput("reboot2.valid", 32'(if_valid), 32'd0);
      step(); checkFetch("rf0", 0, 1);
      step(); checkFetch("rf1", 1, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
